// File: rtl/param_readback_tx_pkg.sv
// Shared constants, state encodings and frame layout for the parameter readback transmitter.
package param_readback_tx_pkg;

  localparam int unsigned FrameLen          = 17;
  localparam logic [7:0]  HeaderDefault     = 8'hA5;
  localparam int unsigned ClksPerBitDefault = 104;

  // Frame-level FSM
  typedef logic [1:0] frame_state_e;
  localparam frame_state_e FrIdle = 2'd0;
  localparam frame_state_e FrLoad = 2'd1;
  localparam frame_state_e FrSend = 2'd2;
  localparam frame_state_e FrDone = 2'd3;

  // Byte serializer FSM
  typedef logic [1:0] tx_state_e;
  localparam tx_state_e TxIdle  = 2'd0;
  localparam tx_state_e TxStart = 2'd1;
  localparam tx_state_e TxData  = 2'd2;
  localparam tx_state_e TxStop  = 2'd3;

  typedef struct packed {
    logic [31:0] per;
    logic [15:0] p1wid;
    logic [15:0] del;
    logic [15:0] p2wid;
    logic [15:0] nut_d;
    logic [7:0]  nut_w;
    logic [6:0]  pr_att;
    logic        cp;
    logic        bl;
  } params_t;

  // Byte at position idx of a frame; multi-byte fields go out MSB byte first.
  function automatic logic [7:0] frame_byte(input params_t    p,
                                            input logic [4:0] idx,
                                            input logic [7:0] hdr,
                                            input logic [7:0] chk);
    logic [7:0] b;
    b = chk;
    case (idx)
      5'd0:    b = hdr;
      5'd1:    b = p.per[31:24];
      5'd2:    b = p.per[23:16];
      5'd3:    b = p.per[15:8];
      5'd4:    b = p.per[7:0];
      5'd5:    b = p.p1wid[15:8];
      5'd6:    b = p.p1wid[7:0];
      5'd7:    b = p.del[15:8];
      5'd8:    b = p.del[7:0];
      5'd9:    b = p.p2wid[15:8];
      5'd10:   b = p.p2wid[7:0];
      5'd11:   b = p.nut_d[15:8];
      5'd12:   b = p.nut_d[7:0];
      5'd13:   b = p.nut_w;
      5'd14:   b = {1'b0, p.pr_att};
      5'd15:   b = {6'b0, p.bl, p.cp};
      default: b = chk;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first. ready is also high in the last stop-bit cycle so a
// pending byte follows with no idle gap.
module uart_tx_byte
  import param_readback_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = ClksPerBitDefault
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam logic [15:0] LastCnt = 16'(CLKS_PER_BIT - 1);

  tx_state_e   state_q;
  logic [15:0] clk_cnt_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shreg_q;
  logic        tx_q;
  logic        bit_last;

  always_comb begin
    bit_last = (clk_cnt_q == LastCnt);
    ready    = (state_q == TxIdle) || ((state_q == TxStop) && bit_last);
  end

  assign tx = tx_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= TxIdle;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        TxIdle: begin
          tx_q <= 1'b1;
          if (valid) begin
            shreg_q   <= data;
            tx_q      <= 1'b0;
            clk_cnt_q <= '0;
            state_q   <= TxStart;
          end
        end
        TxStart: begin
          if (bit_last) begin
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            tx_q      <= shreg_q[0];
            state_q   <= TxData;
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end
        TxData: begin
          if (bit_last) begin
            clk_cnt_q <= '0;
            shreg_q   <= {1'b0, shreg_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= TxStop;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              tx_q      <= shreg_q[1];
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end
        default: begin
          if (bit_last) begin
            clk_cnt_q <= '0;
            if (valid) begin
              shreg_q <= data;
              tx_q    <= 1'b0;
              state_q <= TxStart;
            end else begin
              state_q <= TxIdle;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/param_readback_tx.sv
// Snapshots the pulse-programmer parameters and sends them back as a 17-byte UART frame
// with a trailing XOR checksum.
module param_readback_tx
  import param_readback_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = ClksPerBitDefault,
  parameter logic [7:0]  HEADER       = HeaderDefault
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] per,
  input  logic [15:0] p1wid,
  input  logic [15:0] del,
  input  logic [15:0] p2wid,
  input  logic [15:0] nut_d,
  input  logic [7:0]  nut_w,
  input  logic [6:0]  pr_att,
  input  logic        cp,
  input  logic        bl,
  output logic        RS232_Tx,
  output logic        busy,
  output logic        done
);

  frame_state_e state_q;
  params_t      snap_q;
  params_t      snap_in;
  logic [4:0]   byte_idx_q;
  logic [7:0]   chk_q;
  logic         drain_q;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_accept;

  always_comb begin
    snap_in        = '0;
    snap_in.per    = per;
    snap_in.p1wid  = p1wid;
    snap_in.del    = del;
    snap_in.p2wid  = p2wid;
    snap_in.nut_d  = nut_d;
    snap_in.nut_w  = nut_w;
    snap_in.pr_att = pr_att;
    snap_in.cp     = cp;
    snap_in.bl     = bl;
  end

  // The header is issued straight from LOAD so the start bit leaves two cycles after start.
  always_comb begin
    tx_data   = frame_byte(snap_q, byte_idx_q, HEADER, chk_q);
    tx_valid  = (state_q == FrLoad) ||
                ((state_q == FrSend) && (byte_idx_q < 5'(FrameLen)));
    tx_accept = tx_valid && tx_ready;
    busy      = (state_q == FrSend) || (state_q == FrDone);
    done      = (state_q == FrDone);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= FrIdle;
      snap_q     <= '0;
      byte_idx_q <= '0;
      chk_q      <= '0;
      drain_q    <= 1'b0;
    end else begin
      if (tx_accept) begin
        byte_idx_q <= byte_idx_q + 5'd1;
        if ((byte_idx_q >= 5'd1) && (byte_idx_q <= 5'd15)) begin
          chk_q <= chk_q ^ tx_data;
        end
      end
      case (state_q)
        FrIdle: begin
          byte_idx_q <= '0;
          chk_q      <= '0;
          drain_q    <= 1'b0;
          if (start) begin
            state_q <= FrLoad;
          end
        end
        FrLoad: begin
          snap_q  <= snap_in;
          state_q <= FrSend;
        end
        FrSend: begin
          // ready first rises in the final stop-bit cycle; finish once the serializer is idle.
          if ((byte_idx_q == 5'(FrameLen)) && tx_ready) begin
            drain_q <= 1'b1;
          end
          if (drain_q && tx_ready) begin
            state_q <= FrDone;
          end
        end
        default: begin
          state_q <= FrIdle;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx_byte (
    .clk    (clk),
    .resetn (resetn),
    .data   (tx_data),
    .valid  (tx_valid),
    .ready  (tx_ready),
    .tx     (RS232_Tx)
  );

endmodule

// File: tb/tb_param_readback_tx.sv
// Directed bench for param_readback_tx: decodes the UART line and checks frames and timing.
module tb_param_readback_tx;

  localparam int unsigned Cpb = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] per = '0;
  logic [15:0] p1wid = '0, del = '0, p2wid = '0, nut_d = '0;
  logic [7:0]  nut_w = '0;
  logic [6:0]  pr_att = '0;
  logic        cp = 1'b0, bl = 1'b0;
  logic        tx, busy, done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] rxq[$];
  bit         rx_on = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = '0;
  int         first_fall = -1;
  int         done_cnt = 0;
  int         done_cyc = -1;
  int         busy_cnt = 0;
  int         stop_err = 0;

  logic [7:0] exp_a [17] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A, 8'h0B, 8'h0C, 8'h0D,
                             8'h0E, 8'h0F, 8'h10, 8'h11, 8'h12, 8'h13, 8'h01, 8'h04};
  logic [7:0] exp_b [17] = '{8'hA5, 8'h80, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'hFF, 8'hFF,
                             8'h00, 8'hFF, 8'h12, 8'h34, 8'h55, 8'h7F, 8'h02, 8'h70};

  always #5 clk = ~clk;

  param_readback_tx #(
    .CLKS_PER_BIT (Cpb),
    .HEADER       (8'hA5)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .per      (per),
    .p1wid    (p1wid),
    .del      (del),
    .p2wid    (p2wid),
    .nut_d    (nut_d),
    .nut_w    (nut_w),
    .pr_att   (pr_att),
    .cp       (cp),
    .bl       (bl),
    .RS232_Tx (tx),
    .busy     (busy),
    .done     (done)
  );

  // Advance to the next falling edge and observe cycle cyc.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (!rx_on) begin
      if (tx == 1'b0) begin
        rx_on  = 1'b1;
        rx_cnt = 0;
        if (first_fall < 0) first_fall = cyc;
      end
    end else begin
      rx_cnt++;
      if ((rx_cnt >= 6) && (rx_cnt <= 34) && ((rx_cnt % 4) == 2)) begin
        rx_byte[(rx_cnt - 6) / 4] = tx;
      end
      if (rx_cnt == 38) begin
        if (tx !== 1'b1) stop_err++;
        rxq.push_back(rx_byte);
        rx_on = 1'b0;
      end
    end
  endtask

  task automatic clr_mon();
    rxq.delete();
    rx_on      = 1'b0;
    first_fall = -1;
    done_cnt   = 0;
    done_cyc   = -1;
    busy_cnt   = 0;
    stop_err   = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input string tag, input bit use_b);
    logic [7:0] e;
    check({tag, "_nbytes"}, rxq.size(), 17);
    check({tag, "_stop"}, stop_err, 0);
    for (int i = 0; i < 17; i++) begin
      e = use_b ? exp_b[i] : exp_a[i];
      if (i < rxq.size()) check($sformatf("%s_byte%0d", tag, i), rxq[i], e);
    end
  endtask

  task automatic set_a();
    per = 32'h01020304; p1wid = 16'h0A0B; del = 16'h0C0D; p2wid = 16'h0E0F;
    nut_d = 16'h1011; nut_w = 8'h12; pr_att = 7'h13; cp = 1'b1; bl = 1'b0;
  endtask

  task automatic set_b();
    per = 32'h80000001; p1wid = 16'h0000; del = 16'hFFFF; p2wid = 16'h00FF;
    nut_d = 16'h1234; nut_w = 8'h55; pr_att = 7'h7F; cp = 1'b0; bl = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, r;
    set_a();
    // Reset with start held high: start must be ignored.
    resetn = 1'b0;
    start  = 1'b1;
    repeat (3) tick();
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    resetn = 1'b1;
    start  = 1'b0;
    repeat (5) tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_no_tx", first_fall, 32'hFFFF_FFFF);
    clr_mon();

    // Frame A: timing, snapshot, ignored starts.
    t = cyc;
    start = 1'b1;
    for (int k = 0; k < 2000 && done_cyc < 0; k++) begin
      tick();
      r = cyc - t;
      if (r == 1) start = 1'b0;
      if (r == 10) per = 32'hFFFF_FFFF;
      if (r == 100) start = 1'b1;
      if (r == 101) start = 1'b0;
    end
    check("a_fall", first_fall, t + 2);
    check("a_done_cyc", done_cyc, t + 683);
    check("a_busy_len", busy_cnt, 682);
    start = 1'b1;  // lands in the DONE cycle
    tick();
    start = 1'b0;
    check("a_busy_fall", busy, 0);
    repeat (60) tick();
    check_frame("a", 1'b0);
    check("a_done_cnt", done_cnt, 1);

    // Frame C: reset mid-frame, then a fresh frame.
    clr_mon();
    set_a();
    t = cyc;
    start = 1'b1;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (cyc - t == 1) start = 1'b0;
    end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("c_rst_tx", tx, 1);
    check("c_rst_busy", busy, 0);
    repeat (9) tick();
    check("c_no_done", done_cnt, 0);
    check("c_idle_tx", tx, 1);
    clr_mon();
    t = cyc;
    start = 1'b1;
    for (int k = 0; k < 2000 && done_cyc < 0; k++) begin
      tick();
      if (cyc - t == 1) start = 1'b0;
    end
    check("c_fall", first_fall, t + 2);
    check("c_done_cyc", done_cyc, t + 683);
    check_frame("c", 1'b0);

    // Frame D: back-to-back, start in the first cycle busy is low.
    for (int k = 0; k < 10 && busy; k++) tick();
    check("d_busy_fall_cyc", cyc, t + 684);
    clr_mon();
    set_b();
    t = cyc;
    start = 1'b1;
    for (int k = 0; k < 2000 && done_cyc < 0; k++) begin
      tick();
      if (cyc - t == 1) start = 1'b0;
    end
    check("d_fall", first_fall, t + 2);
    check("d_done_cyc", done_cyc, t + 683);
    check("d_busy_len", busy_cnt, 682);
    repeat (5) tick();
    check_frame("d", 1'b1);
    check("d_done_cnt", done_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
